lsu_bus_ctrl: RTL
=================

LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: bus wait-cycle limit, used only when LSU_TIMEOUT_EN is defined.
REQ-002 SHALL have clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have req_valid_in  input  1  pipeline memory request.
REQ-005 SHALL have req_we_in  input  1  1=store, 0=load.
REQ-006 SHALL have req_addr_in  input  32  byte address.
REQ-007 SHALL have req_wdata_in  input  32  store data, right-aligned.
REQ-008 SHALL have req_size_in  input  2  00 byte, 01 half, 10/11 word.
REQ-009 SHALL have req_unsigned_in  input  1  load zero-extend flag.
REQ-010 SHALL have ahb_addr_out  output  32  bus address, word-aligned (bits [1:0]=00).
REQ-011 SHALL have ahb_wdata_out  output  32  lane-replicated store data.
REQ-012 SHALL have ahb_strb_out  output  4  byte-lane enables.
REQ-013 SHALL have ahb_write_out  output  1  transfer direction.
REQ-014 SHALL have ahb_trans_out  output  1  address phase active.
REQ-015 SHALL have ahb_ready_in  input  1  slave ready, ends the current phase.
REQ-016 SHALL have ahb_resp_in  input  1  1=OKAY, 0=ERROR; sampled with ahb_ready_in in DATA.
REQ-017 SHALL have ahb_rdata_in  input  32  read data.
REQ-018 SHALL have lu_data_out  output  32  registered read word for the load unit.
REQ-019 SHALL have lu_ctrl_out  output  5  registered {unsigned, size[1:0], addr[1:0]} for the load unit.
REQ-020 SHALL have lu_valid_out  output  1  one-cycle pulse: lu_data_out/lu_ctrl_out valid.
REQ-021 SHALL have stall_out  output  1  hold the pipeline.
REQ-022 SHALL have misaligned_out  output  1  one-cycle misalignment exception pulse.
REQ-023 SHALL have bus_err_out  output  1  one-cycle bus-error pulse.

Function
REQ-024 SHALL implement FSM IDLE/ADDR/DATA; misaligned = (half & addr[0]) | (word & addr[1:0]!=00).
REQ-025 IDLE: req_valid_in & misaligned -> misaligned_out pulse next cycle, no bus access, stay IDLE.
REQ-026 IDLE: req_valid_in & aligned -> latch request, go ADDR; ahb_trans_out=1 exactly while in ADDR.
REQ-027 ADDR: ahb_ready_in=1 -> DATA; otherwise hold ADDR with all bus outputs stable.
REQ-028 DATA: ahb_ready_in=1 -> IDLE; load & resp=1 -> capture ahb_rdata_in and pulse lu_valid_out next cycle; resp=0 -> pulse bus_err_out, no lu_valid_out.
REQ-029 Strobes: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111; wdata {4{byte}}/{2{half}}/word; loads drive the same strobes.
REQ-030 stall_out combinational = (IDLE & req_valid_in & aligned) | ADDR | (DATA & ~ahb_ready_in).
REQ-031 Minimum latency: request accepted cycle N, ADDR N+1, DATA N+2, lu_valid_out N+3 with zero wait states.
REQ-032 New requests SHALL be ignored outside IDLE; back-to-back requests are accepted the cycle after return to IDLE.

Reset
REQ-033 rst_in=1 at any clock edge, including mid-transfer, SHALL force IDLE and zero all outputs and registers; the abandoned transfer produces no pulse.

Configuration
REQ-034 With LSU_TIMEOUT_EN defined: wait counter clears on entry to ADDR, increments each ADDR/DATA cycle with ahb_ready_in=0; on reaching TIMEOUT_CYCLES -> pulse bus_err_out, go IDLE. Without it: counter absent, waits indefinitely.

Structure
REQ-035 Package lsu_pkg SHALL hold state encodings, size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and the lu_ctrl_out field layout.
REQ-036 One sub-module, lsu_strb_gen (combinational strobe/wdata replication), SHALL be instantiated.

Verification
REQ-037 Load word addr 0x100, ready=1, rdata 0xDEADBEEF -> lu_valid_out at N+3, lu_data_out 0xDEADBEEF, lu_ctrl_out 0b01000.
REQ-038 Store byte 0xA5 addr 0x203 -> strb 1000, wdata 0xA5A5A5A5, addr 0x200, write=1, no lu_valid_out.
REQ-039 Load half addr 0x101 -> misaligned_out pulse, ahb_trans_out never asserted.
REQ-040 Load with 3 wait states in DATA then resp=0 -> stall held 3 extra cycles, bus_err_out pulse, no lu_valid_out.
REQ-041 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready held 0 -> bus_err_out after 16 wait cycles, IDLE; rst_in during DATA -> IDLE, all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the LSU bus controller: FSM states, access-size codes, load-unit control layout.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Handed to the load unit alongside the raw read word for lane select and extension.
  typedef struct packed {
    logic       is_unsigned;
    logic [1:0] size;
    logic [1:0] offset;
  } lu_ctrl_t;

  localparam int unsigned LU_CTRL_W = $bits(lu_ctrl_t);

  // Size code 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) || ((size >= SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_strb_gen.sv
// Byte-lane strobe generation and store-data lane replication for a sub-word access.
module lsu_strb_gen
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   data,
  output logic [STRB_W-1:0] strb,
  output logic [XLEN-1:0]   data_rep
);

  always_comb begin
    strb     = '0;
    data_rep = '0;
    case (size)
      SZ_BYTE: begin
        strb     = STRB_W'(4'b0001 << offset);
        data_rep = {4{data[7:0]}};
      end
      SZ_HALF: begin
        strb     = offset[1] ? 4'b1100 : 4'b0011;
        data_rep = {2{data[15:0]}};
      end
      default: begin
        strb     = 4'b1111;
        data_rep = data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Single-outstanding LSU to AHB-style bus controller with registered load-unit handoff.
// Optional bus wait timeout is compiled in when LSU_TIMEOUT_EN is defined.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req_valid_in,
  input  logic                 req_we_in,
  input  logic [XLEN-1:0]      req_addr_in,
  input  logic [XLEN-1:0]      req_wdata_in,
  input  logic [1:0]           req_size_in,
  input  logic                 req_unsigned_in,
  output logic [XLEN-1:0]      ahb_addr_out,
  output logic [XLEN-1:0]      ahb_wdata_out,
  output logic [STRB_W-1:0]    ahb_strb_out,
  output logic                 ahb_write_out,
  output logic                 ahb_trans_out,
  input  logic                 ahb_ready_in,
  input  logic                 ahb_resp_in,
  input  logic [XLEN-1:0]      ahb_rdata_in,
  output logic [XLEN-1:0]      lu_data_out,
  output logic [LU_CTRL_W-1:0] lu_ctrl_out,
  output logic                 lu_valid_out,
  output logic                 stall_out,
  output logic                 misaligned_out,
  output logic                 bus_err_out
);

  lsu_state_e state, state_nxt;

  logic                misaligned_c, accept_c, timeout_c;
  logic [STRB_W-1:0]   strb_c;
  logic [XLEN-1:0]     wdata_c;

  logic [XLEN-1:0]     addr_d, wdata_d, data_d;
  logic [STRB_W-1:0]   strb_d;
  logic                write_d, trans_d, lu_valid_d, mis_d, bus_err_d;
  lu_ctrl_t            ctrl_d;

  lsu_strb_gen u_strb_gen (
    .size     (req_size_in),
    .offset   (req_addr_in[1:0]),
    .data     (req_wdata_in),
    .strb     (strb_c),
    .data_rep (wdata_c)
  );

  assign misaligned_c = is_misaligned(req_size_in, req_addr_in[1:0]);
  assign accept_c     = (state == ST_IDLE) && req_valid_in && !misaligned_c;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting_c;

  assign waiting_c = (state != ST_IDLE) && !ahb_ready_in;
  assign timeout_c = waiting_c && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts slave wait cycles across both bus phases of one transfer.
  always_ff @(posedge clk_in) begin
    if (rst_in || accept_c) begin
      wait_cnt <= '0;
    end else if (waiting_c) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_c          = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_c) state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (ahb_ready_in)   state_nxt = ST_DATA;
        else if (timeout_c) state_nxt = ST_IDLE;
      end
      ST_DATA: if (ahb_ready_in || timeout_c) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; bus fields hold until the next accepted request.
  always_comb begin
    addr_d     = ahb_addr_out;
    wdata_d    = ahb_wdata_out;
    strb_d     = ahb_strb_out;
    write_d    = ahb_write_out;
    trans_d    = (state_nxt == ST_ADDR);
    data_d     = lu_data_out;
    ctrl_d     = lu_ctrl_t'(lu_ctrl_out);
    lu_valid_d = 1'b0;
    mis_d      = 1'b0;
    bus_err_d  = 1'b0;

    if (accept_c) begin
      addr_d  = {req_addr_in[XLEN-1:2], 2'b00};
      wdata_d = wdata_c;
      strb_d  = strb_c;
      write_d = req_we_in;
      ctrl_d  = '{is_unsigned: req_unsigned_in, size: req_size_in, offset: req_addr_in[1:0]};
    end

    if ((state == ST_IDLE) && req_valid_in && misaligned_c) begin
      mis_d = 1'b1;
    end

    if ((state == ST_DATA) && ahb_ready_in) begin
      if (!ahb_resp_in) begin
        bus_err_d = 1'b1;
      end else if (!ahb_write_out) begin
        lu_valid_d = 1'b1;
        data_d     = ahb_rdata_in;
      end
    end

    if (timeout_c) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ahb_addr_out   <= '0;
      ahb_wdata_out  <= '0;
      ahb_strb_out   <= '0;
      ahb_write_out  <= 1'b0;
      ahb_trans_out  <= 1'b0;
      lu_data_out    <= '0;
      lu_ctrl_out    <= '0;
      lu_valid_out   <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      ahb_addr_out   <= addr_d;
      ahb_wdata_out  <= wdata_d;
      ahb_strb_out   <= strb_d;
      ahb_write_out  <= write_d;
      ahb_trans_out  <= trans_d;
      lu_data_out    <= data_d;
      lu_ctrl_out    <= ctrl_d;
      lu_valid_out   <= lu_valid_d;
      misaligned_out <= mis_d;
      bus_err_out    <= bus_err_d;
    end
  end

  // Pipeline hold is combinational so the accepting cycle already stalls.
  assign stall_out = !rst_in && (accept_c || (state == ST_ADDR) ||
                                 ((state == ST_DATA) && !ahb_ready_in));

endmodule
